hash_validator: RTL and testbench
=================================

Name: hash_validator

Overview:
- Sits directly downstream of the parallel SHA-256d cores and upstream of the miner controller.
- On the cores' completion pulse, it latches every core's final hash.
- It compares the latched hashes one per cycle against the stored difficulty target.
- It reports the result to the controller as a single-cycle valid or finishedValidating pulse, and holds the winning nonce and hash for readout.

Parameters:
NUM_CORES, 4, number of SHA cores checked per nonce batch; core k hashed nonce nonce_base+k (1..16)
HASH_W, 256, width of hash and target

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
target_load  input  1  one-cycle pulse; loads target_in (same event as the controller's newTarget)
target_in  input  HASH_W  new difficulty target, unsigned big-number
hash_done  input  1  one-cycle pulse from the SHA cores; all hashes are valid this cycle (drives the controller's complete)
hash_in  input  NUM_CORES*HASH_W  concatenated core hashes; core k at bits [k*HASH_W +: HASH_W]
nonce_base  input  32  nonce given to core 0 for this batch; stable while hash_done is asserted
valid  output  1  one-cycle pulse: a hash <= target was found
finishedValidating  output  1  one-cycle pulse: all cores checked, none valid
btc_nonce  output  32  winning nonce
btc_hash  output  HASH_W  winning hash
busy  output  1  high while in SCAN

Behaviour:
- Reset values: valid=0, finishedValidating=0, btc_nonce=0, btc_hash=0, busy=0, target register=0, idx=0, state=IDLE.
- The reset is asynchronous and can occur at any point, including mid-scan. It returns the block to IDLE with no pulse emitted.
- Target register: loaded from target_in on any cycle with target_load=1.
- Abort: target_load during SCAN aborts the scan and returns to IDLE. No valid or finishedValidating pulse is emitted for that batch.
- Hash latch: on hash_done=1 in IDLE:
  - all NUM_CORES hashes and nonce_base are copied into internal registers;
  - idx is set to 0;
  - the state moves to SCAN.
- hash_done in any state other than IDLE is ignored.
- Compare rule: latched hash[idx] <= target, as an unsigned HASH_W-bit magnitude. No byte swapping; the cores deliver numeric order.
- State machine (state, next-state):
  - IDLE: hash_done -> SCAN; otherwise stay in IDLE.
  - SCAN, busy=1:
    - match -> FOUND; btc_nonce <= nonce_base_latched + idx; btc_hash <= hash[idx].
    - else if idx == NUM_CORES-1 -> NONE.
    - else idx <= idx+1, stay in SCAN.
  - FOUND: valid=1 for exactly this cycle -> IDLE.
  - NONE: finishedValidating=1 for exactly this cycle -> IDLE.
- Priority and uniqueness:
  - The lowest matching index wins; the scan stops at the first match.
  - valid and finishedValidating are never both high.
  - At most one pulse is emitted per hash_done.
- Latency, with hash_done in cycle 0:
  - idx k is compared in cycle k+1.
  - valid is high in cycle k+2 for winning index k.
  - finishedValidating is high in cycle NUM_CORES+1.
  - The earliest accepted next hash_done is in cycle k+3 or NUM_CORES+2.
- Outputs valid, finishedValidating and busy are decoded from registered state (glitch-free).
- Nonce arithmetic: 32-bit modulo, so nonce_base=FFFFFFFF with idx 1 gives btc_nonce=00000000. The nonce counter handles overflow detection; this block does not.
- btc_nonce and btc_hash hold their values until the next FOUND or reset. target_load does not clear them.
- Target 0: only an all-zero hash matches. Target all-ones: core 0 always matches.

Test Plan:
1. Reset mid-scan:
   - Stimulus: NUM_CORES=4, target=2^240, hash_done with all hashes >= 2^240; assert n_rst=0 at cycle 2 and hold 2 cycles.
   - Required: no pulse emitted; outputs at reset values; the next hash_done is accepted normally.
2. No match:
   - Stimulus: target=2^240, hash_done with all hashes >= 2^240.
   - Required: finishedValidating=1 in cycle 5 only; valid stays 0; busy high in cycles 1-4.
3. Lowest matching index wins:
   - Stimulus: target=2^240, nonce_base=0x100, core 2 hash = 2^239, core 3 hash = 1.
   - Required: valid in cycle 4; btc_nonce=0x102; btc_hash=2^239.
4. Equality boundary:
   - Stimulus: core 0 hash exactly equal to target, then a second batch with core 0 hash = target+1 and the rest larger.
   - Required: first batch gives valid in cycle 2 with btc_nonce=nonce_base; second batch gives finishedValidating and btc_nonce unchanged.
5. Nonce wrap:
   - Stimulus: nonce_base=0xFFFFFFFE, only core 3 matches.
   - Required: btc_nonce=0x00000001, valid in cycle 5.
6. Abort and ignored pulse:
   - Stimulus: target_load at cycle 2 during SCAN, with an extra hash_done at cycle 1.
   - Required: no pulse emitted; new target in effect; state IDLE at cycle 3; a subsequent batch is validated against the new target.

Source files
------------

// File: rtl/hash_validator.sv
// Checks the latched SHA-256d core hashes against the difficulty target, one core per cycle.
// Reports the first hash that is <= target, or that none of them is, to the miner controller.
//
// state | meaning
// IDLE  | waiting for hash_done from the cores
// SCAN  | comparing latched hash[idx] against the target
// FOUND | winner captured, valid pulses this cycle
// NONE  | all cores checked without a match, finishedValidating pulses this cycle
module hash_validator #(
  parameter int NUM_CORES = 4,
  parameter int HASH_W    = 256
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        target_load,
  input  logic [HASH_W-1:0]           target_in,
  input  logic                        hash_done,
  input  logic [NUM_CORES*HASH_W-1:0] hash_in,
  input  logic [31:0]                 nonce_base,
  output logic                        valid,
  output logic                        finishedValidating,
  output logic [31:0]                 btc_nonce,
  output logic [HASH_W-1:0]           btc_hash,
  output logic                        busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FOUND,
    S_NONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [HASH_W-1:0]  r_target;
  logic [HASH_W-1:0]  r_hash [NUM_CORES];
  logic [31:0]        r_nonce_base;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_btc_nonce;
  logic [HASH_W-1:0]  r_btc_hash;

  logic               w_latch;
  logic               w_advance;
  logic               w_capture;
  logic [HASH_W-1:0]  w_cur_hash;
  logic               w_match;

  assign w_cur_hash = r_hash[r_idx];
  assign w_match    = (w_cur_hash <= r_target);

  // A target change mid-scan aborts the batch, so it outranks a match.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hash_done) begin
          w_state_next = S_SCAN;
          w_latch      = 1'b1;
        end
      end
      S_SCAN: begin
        if (target_load) begin
          w_state_next = S_IDLE;
        end else if (w_match) begin
          w_state_next = S_FOUND;
          w_capture    = 1'b1;
        end else if (r_idx == LAST_IDX) begin
          w_state_next = S_NONE;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_FOUND: w_state_next = S_IDLE;
      S_NONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_target     <= '0;
      r_nonce_base <= '0;
      r_idx        <= '0;
      r_btc_nonce  <= '0;
      r_btc_hash   <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        r_hash[k] <= '0;
      end
    end else begin
      if (target_load) begin
        r_target <= target_in;
      end
      if (w_latch) begin
        r_nonce_base <= nonce_base;
        r_idx        <= '0;
        for (int k = 0; k < NUM_CORES; k++) begin
          r_hash[k] <= hash_in[k*HASH_W +: HASH_W];
        end
      end else if (w_advance) begin
        r_idx <= r_idx + 1'b1;
      end
      // Nonce wraps modulo 2^32; overflow is the nonce counter's concern.
      if (w_capture) begin
        r_btc_nonce <= r_nonce_base + 32'(r_idx);
        r_btc_hash  <= w_cur_hash;
      end
    end
  end

  assign valid              = (r_state == S_FOUND);
  assign finishedValidating = (r_state == S_NONE);
  assign busy               = (r_state == S_SCAN);
  assign btc_nonce          = r_btc_nonce;
  assign btc_hash           = r_btc_hash;

endmodule

// File: tb/tb_hash_validator.sv
// Directed bench for hash_validator: stimulus pushes expected pulses into a queue,
// a negedge monitor pops and compares them whenever valid or finishedValidating fires.
module tb_hash_validator;

  localparam int NC = 4;
  localparam int HW = 256;

  logic            clk;
  logic            n_rst;
  logic            target_load;
  logic [HW-1:0]   target_in;
  logic            hash_done;
  logic [NC*HW-1:0] hash_in;
  logic [31:0]     nonce_base;
  logic            valid;
  logic            finishedValidating;
  logic [31:0]     btc_nonce;
  logic [HW-1:0]   btc_hash;
  logic            busy;

  hash_validator #(.NUM_CORES(NC), .HASH_W(HW)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .target_load        (target_load),
    .target_in          (target_in),
    .hash_done          (hash_done),
    .hash_in            (hash_in),
    .nonce_base         (nonce_base),
    .valid              (valid),
    .finishedValidating (finishedValidating),
    .btc_nonce          (btc_nonce),
    .btc_hash           (btc_hash),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_valid;
    int          at_cyc;
    logic [31:0] nonce;
    logic [HW-1:0] hash;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid && finishedValidating) begin
      checks++;
      errors++;
      $display("FAIL both_pulses actual=1 required=0 (cycle %0d)", cyc);
    end else if (valid || finishedValidating) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual valid=%0b fin=%0b required=none (cycle %0d)",
                 valid, finishedValidating, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_valid", HW'(valid), HW'(e.is_valid));
        chk("pulse_cycle", HW'(cyc), HW'(e.at_cyc));
        chk("btc_nonce", HW'(btc_nonce), HW'(e.nonce));
        chk("btc_hash", btc_hash, e.hash);
      end
    end
  end

  task automatic load_target(input logic [HW-1:0] t);
    @(posedge clk); #1;
    target_load = 1'b1;
    target_in   = t;
    @(posedge clk); #1;
    target_load = 1'b0;
  endtask

  // Issues one batch; off is the hand-computed cycle (relative to hash_done) of the pulse.
  task automatic batch(input logic [31:0] base,
                       input logic [HW-1:0] h0, input logic [HW-1:0] h1,
                       input logic [HW-1:0] h2, input logic [HW-1:0] h3,
                       input bit exp_valid, input int off,
                       input logic [31:0] exp_nonce, input logic [HW-1:0] exp_hash);
    int t0;
    exp_t e;
    @(posedge clk); #1;
    hash_in    = {h3, h2, h1, h0};
    nonce_base = base;
    hash_done  = 1'b1;
    t0 = cyc;
    e.is_valid = exp_valid;
    e.at_cyc   = t0 + off;
    e.nonce    = exp_nonce;
    e.hash     = exp_hash;
    exp_q.push_back(e);
    for (int c = 0; c <= off + 1; c++) begin
      @(negedge clk);
      chk("busy", HW'(busy), HW'(c >= 1 && c < off));
      @(posedge clk); #1;
      hash_done = 1'b0;
    end
  endtask

  logic [HW-1:0] t240, t239, t250, t252, big, ones;

  initial begin
    int t0;
    t240 = 256'd1 << 240;
    t239 = 256'd1 << 239;
    t250 = 256'd1 << 250;
    t252 = 256'd1 << 252;
    big  = 256'd1 << 255;
    ones = '1;

    n_rst = 1'b0; target_load = 1'b0; target_in = '0;
    hash_done = 1'b0; hash_in = '0; nonce_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", HW'(valid), '0);
    chk("rst_fin", HW'(finishedValidating), '0);
    chk("rst_busy", HW'(busy), '0);
    chk("rst_btc_nonce", HW'(btc_nonce), '0);
    chk("rst_btc_hash", btc_hash, '0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    load_target(t240);

    // Lowest matching index wins
    batch(32'h100, t250, t250 + 7, t239, 256'd1, 1'b1, 4, 32'h102, t239);

    // Reset mid-scan: no pulse, outputs back to reset values
    @(posedge clk); #1;
    hash_in = {t240 + 3, big, ones, t240 + 1};
    nonce_base = 32'h55;
    hash_done = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    hash_done = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst_valid", HW'(valid), '0);
      chk("midrst_fin", HW'(finishedValidating), '0);
      chk("midrst_busy", HW'(busy), '0);
      chk("midrst_btc_nonce", HW'(btc_nonce), '0);
      chk("midrst_btc_hash", btc_hash, '0);
      @(posedge clk); #1;
    end
    n_rst = 1'b1;
    repeat (6) @(posedge clk);

    // Target cleared by reset: only an all-zero hash matches
    batch(32'h20, 256'd1, 256'd0, 256'd2, ones, 1'b1, 3, 32'h21, 256'd0);

    load_target(t240);

    // No match
    batch(32'h300, t240 + 1, ones, big, t240 + 2, 1'b0, 5, 32'h21, 256'd0);

    // Equality boundary, then target+1
    batch(32'h5000, t240, big, big, big, 1'b1, 2, 32'h5000, t240);
    batch(32'h6000, t240 + 1, big, ones, t250, 1'b0, 5, 32'h5000, t240);

    // Nonce wrap
    batch(32'hFFFF_FFFE, big, t250, t240 + 9, 256'd5, 1'b1, 5, 32'h0000_0001, 256'd5);

    // All-ones target: core 0 always matches
    load_target(ones);
    batch(32'h7777, ones, 256'd0, 256'd0, 256'd0, 1'b1, 2, 32'h7777, ones);

    // Abort by target_load with an ignored extra hash_done
    load_target(t240);
    @(posedge clk); #1;
    hash_in = {t250, t250, t250, t250};
    nonce_base = 32'h900;
    hash_done = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_c1", HW'(busy), 256'd1);
    @(posedge clk); #1;
    hash_done   = 1'b0;
    target_load = 1'b1;
    target_in   = t252;
    @(posedge clk); #1;
    target_load = 1'b0;
    @(negedge clk);
    chk("abort_idle_c3", HW'(busy), '0);
    repeat (8) @(posedge clk);

    // Subsequent batch sees the new target
    batch(32'hA00, t250 + 1, big, big, big, 1'b1, 2, 32'hA00, t250 + 1);

    repeat (4) @(posedge clk);
    chk("pending_expectations", HW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
